// File: rtl/mine_scheduler.sv
// mine_scheduler: owns the four mine slots shown by the VGA path. Spawns mines on free grid
// cells every SPAWN_TICKS game ticks, retires them after LIFE_TICKS, and flags head hits.
module mine_scheduler #(
   parameter int unsigned GRID_W      = 40,
   parameter int unsigned GRID_H      = 30,
   parameter int unsigned SPAWN_TICKS = 20,
   parameter int unsigned LIFE_TICKS  = 60,
   parameter int unsigned MAX_TRIES   = 8,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] game_status,
   input  logic       tick,
   input  logic [7:0] score,
   input  logic [5:0] apple_x,
   input  logic [4:0] apple_y,
   input  logic [5:0] head_x,
   input  logic [5:0] head_y,
   output logic [5:0] mine_x_0,
   output logic [5:0] mine_x_1,
   output logic [5:0] mine_x_2,
   output logic [5:0] mine_x_3,
   output logic [5:0] mine_y_0,
   output logic [5:0] mine_y_1,
   output logic [5:0] mine_y_2,
   output logic [5:0] mine_y_3,
   output logic [3:0] mine_active,
   output logic       mine_hit
);
   localparam int unsigned SpawnW = $clog2(SPAWN_TICKS + 1);
   localparam int unsigned LifeW  = $clog2(LIFE_TICKS + 1);
   localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
   localparam logic [1:0] StatusRestart = 2'b00;
   localparam logic [1:0] StatusPlay    = 2'b10;

   typedef enum logic [1:0] {StIdle, StGen, StCheck, StPlace} state_e;

   state_e            state_q, state_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [SpawnW-1:0] spawn_cnt_q, spawn_cnt_d;
   logic              spawn_req_q, spawn_req_d;
   logic [TriesW-1:0] tries_q, tries_d;
   logic [5:0]        cand_x_q, cand_x_d, cand_y_q, cand_y_d;
   logic [5:0]        mx_q[4], mx_d[4], my_q[4], my_d[4];
   logic [LifeW-1:0]  life_q[4], life_d[4];
   logic [3:0]        act_q, act_d;
   logic              hit_q, hit_d;

   logic       play_tick, restart, spawn_take, place, slot_free, below_lim, cand_bad;
   logic [4:0] lim_raw;
   logic [2:0] lim, pop;
   logic [1:0] free_idx;
   logic [3:0] hit_vec, exp_vec;
   logic       unused_score;

   assign play_tick    = (game_status == StatusPlay) && tick;
   assign restart      = (game_status == StatusRestart);
   assign unused_score = ^score[3:0];
   assign lim_raw      = 5'd1 + {1'b0, score[7:4]};
   assign lim          = (lim_raw > 5'd4) ? 3'd4 : lim_raw[2:0];
   assign slot_free    = ~&act_q;
   assign below_lim    = pop < lim;
   // Fibonacci LFSR, taps 16,14,13,11
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

   // Occupancy count, lowest free slot, per-slot hit and expiry on a counted tick
   always_comb begin
      pop      = '0;
      free_idx = 2'd0;
      hit_vec  = '0;
      exp_vec  = '0;
      for (int i = 3; i >= 0; i--) begin
         pop = pop + {2'b00, act_q[i]};
         if (!act_q[i]) free_idx = 2'(i);
         hit_vec[i] = play_tick && act_q[i] && (mx_q[i] == head_x) && (my_q[i] == head_y);
         exp_vec[i] = play_tick && act_q[i] && (life_q[i] <= LifeW'(1));
      end
   end

   // Candidate rejection against grid bounds, apple, head and currently active mines
   always_comb begin
      cand_bad = (32'(cand_x_q) >= GRID_W) || (32'(cand_y_q) >= GRID_H) ||
                 ((cand_x_q == apple_x) && (cand_y_q == {1'b0, apple_y})) ||
                 ((cand_x_q == head_x) && (cand_y_q == head_y));
      for (int i = 0; i < 4; i++) begin
         if (act_q[i] && (mx_q[i] == cand_x_q) && (my_q[i] == cand_y_q)) cand_bad = 1'b1;
      end
   end

   // Spawn FSM next state; RESTART overrides everything
   always_comb begin
      state_d    = state_q;
      tries_d    = tries_q;
      cand_x_d   = cand_x_q;
      cand_y_d   = cand_y_q;
      spawn_take = 1'b0;
      place      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (spawn_req_q) begin
               // Request is consumed either way: accepted, or dropped when full/at limit
               spawn_take = 1'b1;
               if (slot_free && below_lim) begin
                  state_d = StGen;
                  tries_d = '0;
               end
            end
         end
         StGen: begin
            cand_x_d = lfsr_q[5:0];
            cand_y_d = lfsr_q[11:6];
            tries_d  = tries_q + 1'b1;
            state_d  = StCheck;
         end
         StCheck: begin
            if (!cand_bad) state_d = StPlace;
            else if (32'(tries_q) < MAX_TRIES) state_d = StGen;
            else state_d = StIdle;
         end
         StPlace: begin
            place   = 1'b1;
            tries_d = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (restart) begin
         state_d    = StIdle;
         tries_d    = '0;
         spawn_take = 1'b0;
         place      = 1'b0;
      end
   end

   // Spawn tick counter and pending request
   always_comb begin
      spawn_cnt_d = spawn_cnt_q;
      spawn_req_d = spawn_req_q;
      if (spawn_take) spawn_req_d = 1'b0;
      if (play_tick) begin
         if (32'(spawn_cnt_q) + 32'd1 >= SPAWN_TICKS) begin
            spawn_cnt_d = '0;
            spawn_req_d = 1'b1;
         end else begin
            spawn_cnt_d = spawn_cnt_q + 1'b1;
         end
      end
      if (restart) begin
         spawn_cnt_d = '0;
         spawn_req_d = 1'b0;
      end
   end

   // Slot state: age, retire on hit/expiry, write the placed mine
   always_comb begin
      act_d = act_q & ~(hit_vec | exp_vec);
      hit_d = |hit_vec;
      for (int i = 0; i < 4; i++) begin
         mx_d[i]   = mx_q[i];
         my_d[i]   = my_q[i];
         life_d[i] = life_q[i];
         if (play_tick && act_q[i]) life_d[i] = life_q[i] - 1'b1;
      end
      if (place) begin
         act_d[free_idx]  = 1'b1;
         mx_d[free_idx]   = cand_x_q;
         my_d[free_idx]   = cand_y_q;
         life_d[free_idx] = LifeW'(LIFE_TICKS);
      end
      if (restart) begin
         act_d = '0;
         hit_d = 1'b0;
         for (int i = 0; i < 4; i++) life_d[i] = '0;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         lfsr_q      <= LFSR_SEED;
         spawn_cnt_q <= '0;
         spawn_req_q <= 1'b0;
         tries_q     <= '0;
         cand_x_q    <= '0;
         cand_y_q    <= '0;
         act_q       <= '0;
         hit_q       <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            mx_q[i]   <= '0;
            my_q[i]   <= '0;
            life_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         spawn_cnt_q <= spawn_cnt_d;
         spawn_req_q <= spawn_req_d;
         tries_q     <= tries_d;
         cand_x_q    <= cand_x_d;
         cand_y_q    <= cand_y_d;
         act_q       <= act_d;
         hit_q       <= hit_d;
         for (int i = 0; i < 4; i++) begin
            mx_q[i]   <= mx_d[i];
            my_q[i]   <= my_d[i];
            life_q[i] <= life_d[i];
         end
      end
   end

   assign mine_x_0    = mx_q[0];
   assign mine_x_1    = mx_q[1];
   assign mine_x_2    = mx_q[2];
   assign mine_x_3    = mx_q[3];
   assign mine_y_0    = my_q[0];
   assign mine_y_1    = my_q[1];
   assign mine_y_2    = my_q[2];
   assign mine_y_3    = my_q[3];
   assign mine_active = act_q;
   assign mine_hit    = hit_q;

endmodule

// File: tb/tb_mine_scheduler.sv
// tb_mine_scheduler: scoreboard bench; stimulus queues expected mine_active values and hit
// snapshots, a negedge monitor pops and compares whenever the DUT changes mine_active or hits.
module tb_mine_scheduler;
   localparam int unsigned MaxTries = 32;
   localparam int unsigned Budget   = 3 + 2 * MaxTries;
   localparam logic [1:0]  Restart  = 2'b00;
   localparam logic [1:0]  Play     = 2'b10;
   localparam logic [1:0]  Die      = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] game_status = Play;
   logic       tick = 1'b0;
   logic [7:0] score = 8'h00;
   logic [5:0] apple_x = 6'd7;
   logic [4:0] apple_y = 5'd7;
   logic [5:0] head_x = 6'd5;
   logic [5:0] head_y = 6'd5;
   logic [5:0] mine_x_0, mine_x_1, mine_x_2, mine_x_3;
   logic [5:0] mine_y_0, mine_y_1, mine_y_2, mine_y_3;
   logic [3:0] mine_active;
   logic       mine_hit;

   always #5 clk = ~clk;

   mine_scheduler #(
      .GRID_W(40), .GRID_H(30), .SPAWN_TICKS(2), .LIFE_TICKS(60),
      .MAX_TRIES(MaxTries), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst(rst), .game_status(game_status), .tick(tick), .score(score),
      .apple_x(apple_x), .apple_y(apple_y), .head_x(head_x), .head_y(head_y),
      .mine_x_0(mine_x_0), .mine_x_1(mine_x_1), .mine_x_2(mine_x_2), .mine_x_3(mine_x_3),
      .mine_y_0(mine_y_0), .mine_y_1(mine_y_1), .mine_y_2(mine_y_2), .mine_y_3(mine_y_3),
      .mine_active(mine_active), .mine_hit(mine_hit)
   );

   int checks = 0;
   int errors = 0;
   int pops = 0;
   int pushed = 0;
   int hits = 0;
   logic [3:0] exp_act[$];
   logic [3:0] exp_hit[$];
   logic [3:0] prev_act = 4'b0000;
   logic       prev_hit = 1'b0;
   logic [5:0] xs[4], ys[4];
   logic [15:0] lfsr_exp;
   int bad;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // Monitor: every mine_active change and every hit pulse is matched against the queues
   always @(negedge clk) begin
      if (mine_active !== prev_act) begin
         if (exp_act.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_change: mine_active %b (was %b), no change queued",
                     mine_active, prev_act);
         end else begin
            pops++;
            chk("mine_active", mine_active, exp_act.pop_front());
         end
      end
      if (mine_hit) begin
         hits++;
         if (prev_hit) chk("hit_pulse_width", 2, 1);
         if (exp_hit.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_hit: mine_hit 1 with mine_active %b, no hit queued",
                     mine_active);
         end else begin
            chk("active_at_hit", mine_active, exp_hit.pop_front());
         end
      end
      prev_act <= mine_active;
      prev_hit <= mine_hit;
   end

   task automatic push_act(input logic [3:0] v);
      exp_act.push_back(v);
      pushed++;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_pops(input int budget, input string name);
      for (int n = 0; n < budget && pops < pushed; n++) @(negedge clk);
      #1;
      chk(name, pops >= pushed, 1);
   endtask

   // Tick until the queued change shows up (one or two ticks per spawn request)
   task automatic tick_until(input string name);
      for (int t = 0; t < 3 && pops < pushed; t++) begin
         pulse_tick();
         for (int n = 0; n < Budget + 2 && pops < pushed; n++) @(negedge clk);
         #1;
      end
      chk(name, pops >= pushed, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_active", mine_active, 0);
      chk("reset_hit", mine_hit, 0);
      chk("reset_coords", {mine_x_0, mine_x_1, mine_x_2, mine_x_3,
                           mine_y_0, mine_y_1, mine_y_2, mine_y_3}, 0);
      chk("reset_lfsr", dut.lfsr_q, 16'hACE1);
      @(posedge clk);
      #1 rst = 1'b0;
      lfsr_exp = 16'hACE1;
      @(negedge clk);
      chk("lfsr_after_release", dut.lfsr_q, lfsr_exp);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         lfsr_exp = lfsr_step(lfsr_exp);
         chk("lfsr_sequence", dut.lfsr_q, lfsr_exp);
      end
      @(posedge clk);
      #1;

      // First spawn: two ticks, bounded latency, legal free coordinates
      push_act(4'b0001);
      pulse_tick();
      pulse_tick();
      wait_pops(Budget + 2, "first_spawn_latency");
      chk("first_x_range", mine_x_0 < 6'd40, 1);
      chk("first_y_range", mine_y_0 < 6'd30, 1);
      chk("first_off_head", (mine_x_0 == head_x) && (mine_y_0 == head_y), 0);
      chk("first_off_apple", (mine_x_0 == apple_x) && (mine_y_0 == {1'b0, apple_y}), 0);

      // Head onto slot 0: one-cycle hit, slot cleared in the same cycle
      head_x = mine_x_0;
      head_y = mine_y_0;
      push_act(4'b0000);
      exp_hit.push_back(4'b0000);
      pulse_tick();
      wait_pops(4, "hit_clear");
      @(negedge clk);
      chk("hit_one_cycle", mine_hit, 0);
      chk("hit_count_1", hits, 1);
      head_x = 6'd5;
      head_y = 6'd5;

      // Limit 4: fill all slots in index order, further requests dropped
      score = 8'h30;
      push_act(4'b0001);
      tick_until("fill_slot0");
      push_act(4'b0011);
      tick_until("fill_slot1");
      push_act(4'b0111);
      tick_until("fill_slot2");
      push_act(4'b1111);
      tick_until("fill_slot3");
      for (int i = 0; i < 16; i++) begin
         pulse_tick();
         idle(8);
      end
      idle(Budget);
      chk("saturated", mine_active, 4'hF);
      xs = '{mine_x_0, mine_x_1, mine_x_2, mine_x_3};
      ys = '{mine_y_0, mine_y_1, mine_y_2, mine_y_3};
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (xs[i] >= 6'd40 || ys[i] >= 6'd30) bad++;
         if (xs[i] == 6'd5 && ys[i] == 6'd5) bad++;
         if (xs[i] == 6'd7 && ys[i] == 6'd7) bad++;
         for (int j = i + 1; j < 4; j++) if (xs[i] == xs[j] && ys[i] == ys[j]) bad++;
      end
      chk("saturated_coords_valid", bad, 0);

      // DIE: 50 ticks must not age anything (slot 0 would otherwise expire)
      game_status = Die;
      for (int i = 0; i < 50; i++) pulse_tick();
      idle(Budget);
      chk("die_freeze", mine_active, 4'hF);

      // RESTART clears all mines on the next cycle
      push_act(4'b0000);
      game_status = Restart;
      @(posedge clk);
      #1 game_status = Play;
      @(negedge clk);
      chk("restart_clear", mine_active, 0);
      score = 8'h00;
      idle(2);

      // Expiry: mine placed, 59 ticks keep it, the 60th retires it
      pulse_tick();
      push_act(4'b0001);
      pulse_tick();
      pulse_tick();
      wait_pops(Budget + 2, "expiry_spawn");
      for (int i = 0; i < 59; i++) pulse_tick();
      idle(5);
      chk("alive_after_59", mine_active, 4'b0001);
      push_act(4'b0000);
      pulse_tick();
      wait_pops(4, "expired_after_60");
      chk("expiry_no_hit", hits, 1);
      idle(Budget);

      // Hit and expiry on the same tick: hit reported, slot cleared once
      push_act(4'b0001);
      pulse_tick();
      pulse_tick();
      wait_pops(Budget + 2, "hitexp_spawn");
      for (int i = 0; i < 59; i++) pulse_tick();
      idle(5);
      head_x = mine_x_0;
      head_y = mine_y_0;
      push_act(4'b0000);
      exp_hit.push_back(4'b0000);
      pulse_tick();
      wait_pops(4, "hitexp_clear");
      @(negedge clk);
      chk("hitexp_hit_count", hits, 2);
      head_x = 6'd5;
      head_y = 6'd5;
      idle(Budget);

      // Async reset while the FSM sits in PLACE
      pulse_tick();
      for (int n = 0; n < Budget + 2 && dut.state_q != 2'd3; n++) @(negedge clk);
      chk("reached_place", dut.state_q == 2'd3, 1);
      rst = 1'b1;
      #1;
      chk("rst_place_active", mine_active, 0);
      chk("rst_place_hit", mine_hit, 0);
      chk("rst_place_coords", {mine_x_0, mine_x_1, mine_x_2, mine_x_3,
                               mine_y_0, mine_y_1, mine_y_2, mine_y_3}, 0);
      chk("rst_place_lfsr", dut.lfsr_q, 16'hACE1);
      idle(2);
      chk("rst_held_active", mine_active, 0);
      rst = 1'b0;
      idle(4);

      chk("act_queue_drained", exp_act.size(), 0);
      chk("hit_queue_drained", exp_hit.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
